// File: rtl/pa_risc_trace_pkg.sv
// Shared definitions for the PA_RISC ID-stage trace unit: opcodes, instruction classes
// and capture modes.
package pa_risc_trace_pkg;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_ARITH = 6'b000010;
    localparam logic [5:0] OP_LDW   = 6'b010010;
    localparam logic [5:0] OP_LDH   = 6'b010001;
    localparam logic [5:0] OP_LDB   = 6'b010000;
    localparam logic [5:0] OP_STW   = 6'b011010;
    localparam logic [5:0] OP_STH   = 6'b011001;
    localparam logic [5:0] OP_STB   = 6'b011000;
    localparam logic [5:0] OP_LDI   = 6'b001101;
    localparam logic [5:0] OP_LDIL  = 6'b001000;
    localparam logic [5:0] OP_ADDI  = 6'b101101;
    localparam logic [5:0] OP_SUBI  = 6'b100101;
    localparam logic [5:0] OP_BL    = 6'b111010;
    localparam logic [5:0] OP_COMBT = 6'b100000;
    localparam logic [5:0] OP_COMBF = 6'b100010;
    localparam logic [5:0] OP_EXTRU = 6'b110100;
    localparam logic [5:0] OP_DEP   = 6'b110101;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ARITH   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_IMM     = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_SHIFT   = 3'd6,
        CLS_UNKNOWN = 3'd7
    } inst_class_e;

    typedef enum logic [1:0] {
        MODE_CONT     = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_TRIG     = 2'b10,
        MODE_CONT_ALT = 2'b11
    } trace_mode_e;

endpackage

// File: rtl/pa_risc_inst_classifier.sv
// Combinational opcode-to-class decode; shared between the trace unit and the bench display.
module pa_risc_inst_classifier
    import pa_risc_trace_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] inst_class
);

    // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
    always_comb begin
        inst_class = CLS_UNKNOWN;
        case (opcode)
            OP_NOP:                        inst_class = CLS_NOP;
            OP_ARITH:                      inst_class = CLS_ARITH;
            OP_LDW, OP_LDH, OP_LDB:        inst_class = CLS_LOAD;
            OP_STW, OP_STH, OP_STB:        inst_class = CLS_STORE;
            OP_LDI, OP_LDIL, OP_ADDI,
            OP_SUBI:                       inst_class = CLS_IMM;
            OP_BL, OP_COMBT, OP_COMBF:     inst_class = CLS_BRANCH;
            OP_EXTRU, OP_DEP:              inst_class = CLS_SHIFT;
            default:                       inst_class = CLS_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/pa_risc_trace_unit.sv
// ID-stage trace unit: per-class saturating counters plus a circular {pc, instr, class}
// buffer with continuous, one-shot and opcode-triggered capture, read back through a registered port.
module pa_risc_trace_unit
    import pa_risc_trace_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int PC_W   = 32,
    parameter  int CNT_W  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              inst_valid,
    input  logic [31:0]       instr,
    input  logic [PC_W-1:0]   pc,
    input  logic [1:0]        mode,
    input  logic [5:0]        trig_opcode,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [2:0]        cnt_sel,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [PC_W-1:0]   rd_pc,
    output logic [31:0]       rd_instr,
    output logic [2:0]        rd_class,
    output logic [CNT_W-1:0]  cnt_value,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              triggered,
    output logic              done
);

    logic [2:0]        inst_class;
    logic [PC_W-1:0]   buf_pc    [DEPTH];
    logic [31:0]       buf_instr [DEPTH];
    logic [2:0]        buf_class [DEPTH];
    logic [CNT_W-1:0]  class_cnt [8];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] post_remaining;
    logic [ADDR_W-1:0] oldest;
    logic [ADDR_W-1:0] rd_addr;
    logic              count_event;
    logic              capture;
    logic              trig_hit;
    logic              rd_miss;

    pa_risc_inst_classifier u_classifier (
        .opcode     (instr[31:26]),
        .inst_class (inst_class)
    );

    assign count_event = enable & inst_valid & ~clear;
    assign capture     = count_event & ~done;
    assign trig_hit    = capture && (mode == MODE_TRIG) && !triggered && (instr[31:26] == trig_opcode);
    assign full        = (count == (ADDR_W+1)'(DEPTH));

    // When full, count's low bits are zero, so the oldest slot is the one about to be overwritten.
    assign oldest  = wr_ptr - count[ADDR_W-1:0];
    assign rd_addr = oldest + rd_idx;
    assign rd_miss = ({1'b0, rd_idx} >= count);

    // NOTE: the trace array carries no reset; slots beyond count are never visible through the read port.
    always_ff @(posedge clk) begin
        if (capture && !reset) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= instr;
            buf_class[wr_ptr] <= inst_class;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            count          <= '0;
            triggered      <= 1'b0;
            done           <= 1'b0;
            post_remaining <= '0;
        end else if (clear) begin
            wr_ptr         <= '0;
            count          <= '0;
            triggered      <= 1'b0;
            done           <= 1'b0;
            post_remaining <= '0;
        end else if (capture) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (!full) begin
                count <= count + (ADDR_W+1)'(1);
            end
            if (mode == MODE_ONESHOT && count == (ADDR_W+1)'(DEPTH - 1)) begin
                done <= 1'b1;
            end
            if (trig_hit) begin
                triggered      <= 1'b1;
                post_remaining <= post_count;
                if (post_count == '0) begin
                    done <= 1'b1;
                end
            end else if (mode == MODE_TRIG && triggered && post_remaining != '0) begin
                post_remaining <= post_remaining - ADDR_W'(1);
                if (post_remaining == ADDR_W'(1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // Counting ignores done so statistics keep running after a capture window closes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) class_cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 8; i++) class_cnt[i] <= '0;
        end else if (count_event && class_cnt[inst_class] != '1) begin
            class_cnt[inst_class] <= class_cnt[inst_class] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            rd_pc     <= '0;
            rd_instr  <= '0;
            rd_class  <= '0;
            cnt_value <= '0;
        end else begin
            rd_valid  <= rd_en;
            cnt_value <= class_cnt[cnt_sel];
            if (rd_en) begin
                rd_err <= rd_miss;
                if (rd_miss) begin
                    rd_pc    <= '0;
                    rd_instr <= '0;
                    rd_class <= '0;
                end else begin
                    rd_pc    <= buf_pc[rd_addr];
                    rd_instr <= buf_instr[rd_addr];
                    rd_class <= buf_class[rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_pa_risc_trace_unit.sv
// Self-checking bench for pa_risc_trace_unit: table-driven class vectors, directed capture-mode
// sequences and a read-response scoreboard; a second instance with CNT_W=4 exercises saturation.
module tb_pa_risc_trace_unit;

    localparam int DEPTH  = 16;
    localparam int PC_W   = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic              inst_valid = 1'b0;
    logic [31:0]       instr = '0;
    logic [PC_W-1:0]   pc = '0;
    logic [1:0]        mode = 2'b00;
    logic [5:0]        trig_opcode = '0;
    logic [ADDR_W-1:0] post_count = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_idx = '0;
    logic [2:0]        cnt_sel = '0;

    logic              rd_valid, rd_err, full, triggered, done;
    logic [PC_W-1:0]   rd_pc;
    logic [31:0]       rd_instr;
    logic [2:0]        rd_class;
    logic [31:0]       cnt_value;
    logic [ADDR_W:0]   count;

    logic              s_rd_valid, s_rd_err, s_full, s_triggered, s_done;
    logic [PC_W-1:0]   s_rd_pc;
    logic [31:0]       s_rd_instr;
    logic [2:0]        s_rd_class;
    logic [3:0]        s_cnt_value;
    logic [ADDR_W:0]   s_count;

    pa_risc_trace_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inst_valid(inst_valid),
        .instr(instr), .pc(pc), .mode(mode), .trig_opcode(trig_opcode), .post_count(post_count),
        .rd_en(rd_en), .rd_idx(rd_idx), .cnt_sel(cnt_sel),
        .rd_valid(rd_valid), .rd_err(rd_err), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_class(rd_class), .cnt_value(cnt_value), .count(count), .full(full),
        .triggered(triggered), .done(done)
    );

    pa_risc_trace_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inst_valid(inst_valid),
        .instr(instr), .pc(pc), .mode(mode), .trig_opcode(trig_opcode), .post_count(post_count),
        .rd_en(rd_en), .rd_idx(rd_idx), .cnt_sel(cnt_sel),
        .rd_valid(s_rd_valid), .rd_err(s_rd_err), .rd_pc(s_rd_pc), .rd_instr(s_rd_instr),
        .rd_class(s_rd_class), .cnt_value(s_cnt_value), .count(s_count), .full(s_full),
        .triggered(s_triggered), .done(s_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] sub;
        logic [2:0] cls;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  cls;
    } rd_exp_t;

    vec_t    vecs [21];
    rd_exp_t sb [$];
    int      n_checks = 0;
    int      n_fail = 0;
    int      exp_cnt [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] make_instr(input logic [5:0] op, input int p, input logic [5:0] sub);
        return {op, 14'(p), sub, 6'h00};
    endfunction

    // One clock; any read response arriving on this edge is matched against the scoreboard.
    task automatic tick();
        rd_exp_t e;
        @(posedge clk);
        #1;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                check("rd_valid_without_request", rd_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("rd_err", rd_err, e.err);
                check("rd_pc", rd_pc, e.pc);
                check("rd_instr", rd_instr, e.instr);
                check("rd_class", rd_class, e.cls);
            end
        end
    endtask

    task automatic issue(input logic v, input logic [5:0] op, input int p, input logic [5:0] sub);
        inst_valid = v;
        instr      = make_instr(op, p, sub);
        pc         = PC_W'(p);
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic read(input int idx, input logic err, input logic [5:0] op, input int p,
                        input logic [5:0] sub, input logic [2:0] cls);
        rd_exp_t e;
        e = '0;
        e.err = err;
        if (!err) begin
            e.pc    = 32'(p);
            e.instr = make_instr(op, p, sub);
            e.cls   = cls;
        end
        rd_en  = 1'b1;
        rd_idx = ADDR_W'(idx);
        sb.push_back(e);
        tick();
        rd_en = 1'b0;
        check($sformatf("rd_response_idx%0d", idx), 64'(sb.size()), 64'd0);
    endtask

    task automatic check_cnt(input string name, input logic [2:0] sel, input logic [31:0] exp);
        cnt_sel = sel;
        tick();
        check(name, cnt_value, exp);
    endtask

    task automatic do_clear(input logic with_valid);
        clear      = 1'b1;
        inst_valid = with_valid;
        instr      = make_instr(6'b000010, 99, 6'h0);
        pc         = PC_W'(99);
        tick();
        clear      = 1'b0;
        inst_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{6'b000000, 6'h00, 3'd0};
        vecs[1]  = '{6'b000010, 6'h0a, 3'd1};
        vecs[2]  = '{6'b000010, 6'h3f, 3'd1};
        vecs[3]  = '{6'b010010, 6'h00, 3'd2};
        vecs[4]  = '{6'b010001, 6'h00, 3'd2};
        vecs[5]  = '{6'b010000, 6'h00, 3'd2};
        vecs[6]  = '{6'b011010, 6'h00, 3'd3};
        vecs[7]  = '{6'b011001, 6'h00, 3'd3};
        vecs[8]  = '{6'b011000, 6'h00, 3'd3};
        vecs[9]  = '{6'b001101, 6'h00, 3'd4};
        vecs[10] = '{6'b001000, 6'h00, 3'd4};
        vecs[11] = '{6'b101101, 6'h00, 3'd4};
        vecs[12] = '{6'b100101, 6'h00, 3'd4};
        vecs[13] = '{6'b111010, 6'h00, 3'd5};
        vecs[14] = '{6'b100000, 6'h00, 3'd5};
        vecs[15] = '{6'b100010, 6'h00, 3'd5};
        vecs[16] = '{6'b110100, 6'h00, 3'd6};
        vecs[17] = '{6'b110101, 6'h00, 3'd6};
        vecs[18] = '{6'b111111, 6'h00, 3'd7};
        vecs[19] = '{6'b000001, 6'h00, 3'd7};
        vecs[20] = '{6'b010011, 6'h00, 3'd7};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_rd_pc", rd_pc, 0);
        check("rst_cnt_value", cnt_value, 0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();

        // Continuous mode wraps and overwrites the oldest entries
        mode = 2'b00;
        for (int p = 0; p < 20; p++) issue(1'b1, 6'b000010, p, 6'h0);
        check("t1_count", count, 16);
        check("t1_full", full, 1);
        check("t1_done", done, 0);
        read(0, 1'b0, 6'b000010, 4, 6'h0, 3'd1);
        read(15, 1'b0, 6'b000010, 19, 6'h0, 3'd1);
        check_cnt("t1_cnt_arith", 3'd1, 32'd20);
        check("t1_small_cnt_saturated", s_cnt_value, 4'd15);

        // One-shot stops after DEPTH entries, counting continues
        do_clear(1'b0);
        mode = 2'b01;
        for (int p = 0; p < 20; p++) begin
            issue(1'b1, 6'b010010, p, 6'h0);
            if (p == 14) check("t2_done_before_full", done, 0);
            if (p == 15) check("t2_done_at_full", done, 1);
        end
        check("t2_count", count, 16);
        check("t2_done_held", done, 1);
        read(0, 1'b0, 6'b010010, 0, 6'h0, 3'd2);
        read(15, 1'b0, 6'b010010, 15, 6'h0, 3'd2);
        check_cnt("t2_cnt_load", 3'd2, 32'd20);

        // Triggered on BL at pc 7 with three post-trigger entries; second BL must not retrigger
        do_clear(1'b0);
        mode        = 2'b10;
        trig_opcode = 6'b111010;
        post_count  = 4'd3;
        for (int p = 0; p < 15; p++) begin
            issue(1'b1, (p == 7 || p == 9) ? 6'b111010 : 6'b000010, p, 6'h0);
            if (p == 6)  check("t3_not_triggered_yet", triggered, 0);
            if (p == 7)  check("t3_triggered", triggered, 1);
            if (p == 7)  check("t3_done_at_trigger", done, 0);
            if (p == 9)  check("t3_done_before_last", done, 0);
            if (p == 10) check("t3_done_after_post", done, 1);
        end
        check("t3_count", count, 11);
        read(10, 1'b0, 6'b000010, 10, 6'h0, 3'd1);
        read(7, 1'b0, 6'b111010, 7, 6'h0, 3'd5);
        read(11, 1'b1, 6'b0, 0, 6'h0, 3'd0);
        check_cnt("t3_cnt_arith", 3'd1, 32'd13);
        check_cnt("t3_cnt_branch", 3'd5, 32'd2);

        // post_count = 0 stops on the trigger entry itself
        do_clear(1'b0);
        post_count = 4'd0;
        issue(1'b1, 6'b000010, 0, 6'h0);
        issue(1'b1, 6'b111010, 1, 6'h0);
        check("t3b_triggered", triggered, 1);
        check("t3b_done", done, 1);
        issue(1'b1, 6'b000010, 2, 6'h0);
        check("t3b_count_frozen", count, 2);
        read(1, 1'b0, 6'b111010, 1, 6'h0, 3'd5);

        // Class table with interleaved invalid cycles and one disabled cycle
        do_clear(1'b0);
        mode = 2'b11;
        for (int s = 0; s < 8; s++) exp_cnt[s] = 0;
        for (int i = 0; i < 21; i++) begin
            issue(1'b1, vecs[i].op, i, vecs[i].sub);
            exp_cnt[vecs[i].cls]++;
            issue(1'b0, 6'b111010, 100 + i, 6'h0);
        end
        enable = 1'b0;
        issue(1'b1, 6'b000000, 200, 6'h0);
        enable = 1'b1;
        check("t4_count", count, 16);
        for (int k = 0; k < 16; k++)
            read(k, 1'b0, vecs[k+5].op, k + 5, vecs[k+5].sub, vecs[k+5].cls);
        for (int s = 0; s < 8; s++)
            check_cnt($sformatf("t4_cnt_class%0d", s), 3'(s), 32'(exp_cnt[s]));

        // Clear wins over a simultaneous valid instruction
        do_clear(1'b1);
        check("t5_count", count, 0);
        check("t5_full", full, 0);
        read(0, 1'b1, 6'b0, 0, 6'h0, 3'd0);
        for (int s = 0; s < 8; s++)
            check_cnt($sformatf("t5_cnt_class%0d", s), 3'(s), 32'd0);
        issue(1'b1, 6'b000010, 50, 6'h0);
        check("t5_capture_resumes", count, 1);

        // Saturation on the narrow instance, then asynchronous reset mid-stream
        do_clear(1'b0);
        mode = 2'b00;
        for (int p = 0; p < 20; p++) issue(1'b1, 6'b000000, p, 6'h0);
        check_cnt("t6_cnt_nop_wide", 3'd0, 32'd20);
        check("t6_cnt_nop_small", s_cnt_value, 4'd15);
        read(0, 1'b0, 6'b000000, 4, 6'h0, 3'd0);
        inst_valid = 1'b1;
        instr      = make_instr(6'b000010, 21, 6'h0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_count", count, 0);
        check("t6_rst_full", full, 0);
        check("t6_rst_rd_valid", rd_valid, 0);
        check("t6_rst_rd_pc", rd_pc, 0);
        check("t6_rst_cnt_value", cnt_value, 0);
        check("t6_rst_small_cnt_value", s_cnt_value, 0);
        tick();
        check("t6_rst_count_held", count, 0);
        inst_valid = 1'b0;
        reset      = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_risc_trace_unit.md
Name: pa_risc_trace_unit

Overview:
Synthesizable successor to the bench-side instruction decode/display logic: classifies every valid ID-stage instruction of the PA_RISC pipeline into an instruction class, and keeps per-class saturating counters. Records {PC, instruction, class} into a parametrised circular trace buffer with continuous, one-shot and opcode-triggered capture modes. Sits beside the IF/ID register, tapping InstructionOut and PCFrontOut; readout is a registered random-access port for debug.

Parameters:
DEPTH, 16, trace entries; power of 2, >= 2
PC_W, 32, captured PC width
CNT_W, 32, width of each class counter
ADDR_W, $clog2(DEPTH), derived index width; not overridden

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  master enable for capture and counting
clear  in  1  synchronous clear of buffer, counters, trigger/done flags
inst_valid  in  1  instr/pc valid this cycle (not stalled, not flushed)
instr  in  32  ID-stage instruction word
pc  in  PC_W  PC of instr
mode  in  2  00 continuous, 01 one-shot, 10 triggered, 11 = continuous
trig_opcode  in  6  trigger opcode (instr[31:26]) for mode 10
post_count  in  ADDR_W  entries captured after the trigger entry
rd_en  in  1  read request
rd_idx  in  ADDR_W  read index, 0 = oldest stored entry
cnt_sel  in  3  class counter select
rd_valid  out  1  read data valid, one cycle after rd_en
rd_err  out  1  with rd_valid: rd_idx >= count
rd_pc  out  PC_W  entry PC
rd_instr  out  32  entry instruction
rd_class  out  3  entry class
cnt_value  out  CNT_W  registered value of selected counter
count  out  ADDR_W+1  entries stored, 0..DEPTH
full  out  1  count == DEPTH
triggered  out  1  trigger seen (mode 10)
done  out  1  capture stopped

Behaviour:
- Reset: every output, pointer, counter, flag and rd_* register = 0; buffer contents don't-care.
- Class by instr[31:26]: 0 NOP 000000; 1 ARITH 000010; 2 LOAD 010010/010001/010000; 3 STORE 011010/011001/011000; 4 IMM 001101/001000/101101/100101; 5 BRANCH 111010/100000/100010; 6 SHIFT 110100/110101; 7 UNKNOWN otherwise. ARITH with unlisted instr[11:6] is still class 1; subop decode is not done.
- Count event = enable & inst_valid & !clear: counter[class] += 1, saturating at all ones; counting continues when done=1.
- Capture event = count event & !done: write {pc, instr, class} at wr_ptr; wr_ptr += 1 mod DEPTH (wraps); count += 1, saturating at DEPTH. When full, the oldest entry is overwritten.
- Oldest physical slot = (wr_ptr - count) mod DEPTH; physical read address = oldest + rd_idx mod DEPTH.
- Mode 01: done set in the same edge that makes count reach DEPTH.
- Mode 10: capture runs continuously. A capture event with instr[31:26] == trig_opcode and triggered=0 sets triggered and loads post_remaining = post_count. While triggered, each later capture decrements post_remaining. done is set on the capture that makes post_remaining 0; with post_count=0, done is set on the trigger entry itself.
- Mode 11 behaves as 00; done is never set in 00.
- mode changes take effect on the next event; done and triggered are cleared only by clear or reset.
- Read: rd_en sampled at edge N → rd_valid=1 with data at N+1; rd_valid=0 otherwise (data held). Read sees state before any same-edge write. rd_err=1 and data zeroed if rd_idx >= count.
- cnt_value: registered every cycle from counter[cnt_sel], so one-cycle latency.
- clear: counters, count, wr_ptr, triggered, done, post_remaining = 0 at the next edge. Wins over a simultaneous capture; that instruction is neither counted nor stored.
- reset asserted mid-capture: immediate clear, no partial write.

Decomposition:
- Shared package pa_risc_trace_pkg: opcode localparams (matching the decoder in the control unit), class codes CLS_NOP..CLS_UNKNOWN, mode codes.
- Sub-module pa_risc_inst_classifier: combinational opcode → class. It is reused by the bench's keyword display.
- The buffer is a plain register array in the top.

Test Plan:
1. Mode 00, DEPTH=16, 20 valid ADDs at pc 0..19 → count=16, full=1, rd_idx 0 returns pc 4, rd_idx 15 returns pc 19, counter[1]=20.
2. Mode 01, 20 valid instructions → done=1 after the 16th; rd_idx 0 returns pc 0; counters still reach 20.
3. Mode 10, trig_opcode=111010, post_count=3, stream with BL at pc 7 → triggered at pc 7, done after pc 10; rd_idx count-1 returns pc 10.
4. Mix of LDW, STB, LDI, COMBF, EXTRU, opcode 111111, inst_valid toggling → each class counter equals its injected valid count; invalid cycles are not counted.
5. clear and inst_valid in the same cycle, then rd_idx 0 → count=0, rd_err=1, all counters 0.
6. CNT_W=4 with 20 NOPs → counter[0]=15 (saturated); reset mid-stream → all outputs 0 at once.
